// File: rtl/mmu_split_ctrl.sv
// Two-way split dispatch controller.
// One request is latched, then offered to two downstream branches at once.
// Each branch is accepted independently. The transaction completes once both
// branches have returned a completion pulse.
// Optional watchdog: define MMU_SPLIT_TIMEOUT_EN to build it in.
// All outputs come from registers only; there is no input-to-output path.
module mmu_split_ctrl #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_driveNext0,
    output logic              o_driveNext1,
    input  logic              i_ackNext0,
    input  logic              i_ackNext1,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_freeNext0,
    input  logic              i_freeNext1,
    output logic              o_complete,
    output logic              o_busy,
    output logic              o_timeout
);

    typedef enum logic [1:0] {StIdle, StDispatch, StWait, StComplete} state_e;

    state_e            state_q, state_d;
    logic [1:0]        acc_q, acc_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        drive;
    logic [1:0]        acc_nxt;
    logic [1:0]        done_nxt;
    logic              expire;

    // A branch is offered only while it is still unaccepted in DISPATCH.
    assign drive    = (state_q == StDispatch) ? ~acc_q : 2'b00;
    assign acc_nxt  = acc_q | (drive & {i_ackNext1, i_ackNext0});
    // A free pulse counts only for a branch that is accepted by now.
    assign done_nxt = done_q | ({i_freeNext1, i_freeNext0} & acc_nxt);

`ifdef MMU_SPLIT_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    assign expire = ((state_q == StDispatch) || (state_q == StWait)) && (cnt_q == TmoLast);

    // Watchdog counter: clears on entry to DISPATCH, runs while a transaction is in flight.
    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (state_q == StIdle) begin
            if (i_req_valid) cnt_d = '0;
        end else if ((state_q == StDispatch) || (state_q == StWait)) begin
            cnt_d = cnt_q + 16'd1;
            // Completion in the same cycle wins over expiry.
            if (expire && (done_nxt != 2'b11)) tmo_d = 1'b1;
        end
    end

    // Watchdog registers; the timeout flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign o_timeout = tmo_q;
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Next-state logic for the transaction FSM and its per-branch bookkeeping.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        done_d  = done_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    data_d  = i_req_data;
                    acc_d   = 2'b00;
                    done_d  = 2'b00;
                    state_d = StDispatch;
                end
            end
            StDispatch, StWait: begin
                acc_d  = acc_nxt;
                done_d = done_nxt;
                if (done_nxt == 2'b11) begin
                    state_d = StComplete;
                end else if (expire) begin
                    acc_d   = 2'b00;
                    done_d  = 2'b00;
                    state_d = StIdle;
                end else if (acc_nxt == 2'b11) begin
                    state_d = StWait;
                end
            end
            StComplete: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= 2'b00;
            done_q  <= 2'b00;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign o_req_ready  = (state_q == StIdle);
    assign o_driveNext0 = drive[0];
    assign o_driveNext1 = drive[1];
    assign o_complete   = (state_q == StComplete);
    assign o_busy       = (state_q != StIdle);
    assign o_data       = data_q;

endmodule

// File: tb/tb_mmu_split_ctrl.sv
// Bench for mmu_split_ctrl: a transaction-level reference model with a per-cycle
// compare process, and directed scenarios carrying hand-computed literal checks.
module tb_mmu_split_ctrl;

    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 8;
`ifdef MMU_SPLIT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic [DW-1:0] i_req_data;
    logic          o_driveNext0, o_driveNext1;
    logic          i_ackNext0, i_ackNext1;
    logic [DW-1:0] o_data;
    logic          i_freeNext0, i_freeNext1;
    logic          o_complete;
    logic          o_busy;
    logic          o_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    mmu_split_ctrl #(
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_data  (i_req_data),
        .o_driveNext0(o_driveNext0),
        .o_driveNext1(o_driveNext1),
        .i_ackNext0  (i_ackNext0),
        .i_ackNext1  (i_ackNext1),
        .o_data      (o_data),
        .i_freeNext0 (i_freeNext0),
        .i_freeNext1 (i_freeNext1),
        .o_complete  (o_complete),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction with a set of accepted and finished branches.
    logic          m_started = 1'b0;
    logic          m_active, m_cpl, m_tmo;
    logic [1:0]    m_acc, m_done;
    logic [DW-1:0] m_data;
    int            m_age;
    logic [1:0]    m_hs, m_nacc, m_ndone;

    assign m_hs    = m_active ? (~m_acc & {i_ackNext1, i_ackNext0}) : 2'b00;
    assign m_nacc  = m_acc | m_hs;
    assign m_ndone = m_done | ({i_freeNext1, i_freeNext0} & m_nacc);

    always @(posedge clk) begin
        if (rst) begin
            m_started <= 1'b1;
            m_active  <= 1'b0;
            m_cpl     <= 1'b0;
            m_tmo     <= 1'b0;
            m_acc     <= 2'b00;
            m_done    <= 2'b00;
            m_data    <= '0;
            m_age     <= 0;
        end else if (m_cpl) begin
            m_cpl <= 1'b0;
        end else if (!m_active) begin
            if (i_req_valid) begin
                m_active <= 1'b1;
                m_data   <= i_req_data;
                m_acc    <= 2'b00;
                m_done   <= 2'b00;
                m_age    <= 0;
            end
        end else begin
            m_acc  <= m_nacc;
            m_done <= m_ndone;
            if (m_ndone == 2'b11) begin
                m_active <= 1'b0;
                m_cpl    <= 1'b1;
            end else if (TMO_EN && (m_age == int'(TMO) - 1)) begin
                m_active <= 1'b0;
                m_acc    <= 2'b00;
                m_done   <= 2'b00;
                m_tmo    <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_started) begin
            chk("cmp_ready", 32'(o_req_ready), 32'(!m_active && !m_cpl));
            chk("cmp_drive0", 32'(o_driveNext0), 32'(m_active && !m_acc[0]));
            chk("cmp_drive1", 32'(o_driveNext1), 32'(m_active && !m_acc[1]));
            chk("cmp_complete", 32'(o_complete), 32'(m_cpl));
            chk("cmp_busy", 32'(o_busy), 32'(m_active || m_cpl));
            chk("cmp_data", o_data, m_data);
            chk("cmp_timeout", 32'(o_timeout), 32'(m_tmo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        i_req_valid = 1'b0;
        i_ackNext0  = 1'b0;
        i_ackNext1  = 1'b0;
        i_freeNext0 = 1'b0;
        i_freeNext1 = 1'b0;
    endtask

    // Handshake a request; returns in cycle 1 (first DISPATCH cycle) with inputs cleared.
    task automatic start_req(input logic [DW-1:0] d);
        i_req_valid = 1'b1;
        i_req_data  = d;
        tick();
        clr_in();
        i_req_data = 32'hDEAD_BEEF;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        i_req_data = '0;
        tick();
        tick();
        // Reset state
        chk("rst_ready", 32'(o_req_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_drive", 32'({o_driveNext1, o_driveNext0}), 32'd0);
        chk("rst_complete", 32'(o_complete), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(o_req_ready), 32'd1);

        // Minimum latency: acks and frees together in cycle 1.
        start_req(32'hA5A5_0001);
        chk("a_drive_c1", 32'({o_driveNext1, o_driveNext0}), 32'd3);
        chk("a_data_c1", o_data, 32'hA5A5_0001);
        i_ackNext0 = 1'b1; i_ackNext1 = 1'b1; i_freeNext0 = 1'b1; i_freeNext1 = 1'b1;
        tick();
        clr_in();
        chk("a_complete_c2", 32'(o_complete), 32'd1);
        chk("a_ready_c2", 32'(o_req_ready), 32'd0);
        chk("a_data_c2", o_data, 32'hA5A5_0001);
        tick();
        chk("a_ready_c3", 32'(o_req_ready), 32'd1);
        chk("a_complete_c3", 32'(o_complete), 32'd0);
        chk("a_data_c3", o_data, 32'hA5A5_0001);

        // Staggered acks: branch 0 at cycle 1, branch 1 at cycle 4.
        start_req(32'h1111_2222);
        i_ackNext0 = 1'b1;
        tick();
        i_ackNext0 = 1'b0;
        chk("b_drive0_c2", 32'(o_driveNext0), 32'd0);
        chk("b_drive1_c2", 32'(o_driveNext1), 32'd1);
        tick();
        chk("b_drive1_c3", 32'(o_driveNext1), 32'd1);
        tick();
        chk("b_drive1_c4", 32'(o_driveNext1), 32'd1);
        i_ackNext1 = 1'b1;
        tick();
        i_ackNext1 = 1'b0;
        chk("b_drive_c5", 32'({o_driveNext1, o_driveNext0}), 32'd0);
        chk("b_busy_c5", 32'(o_busy), 32'd1);
        i_freeNext0 = 1'b1;
        tick();
        i_freeNext0 = 1'b0;
        i_freeNext1 = 1'b1;
        chk("b_complete_c6", 32'(o_complete), 32'd0);
        tick();
        i_freeNext1 = 1'b0;
        chk("b_complete_c7", 32'(o_complete), 32'd1);
        chk("b_data_c7", o_data, 32'h1111_2222);
        tick();

        // Free on branch 1 before its ack is ignored; repeated free0 has no effect.
        start_req(32'h0000_0003);
        i_ackNext0 = 1'b1; i_freeNext0 = 1'b1; i_freeNext1 = 1'b1;
        tick();
        clr_in();
        i_ackNext1 = 1'b1;
        chk("c_complete_c2", 32'(o_complete), 32'd0);
        chk("c_drive1_c2", 32'(o_driveNext1), 32'd1);
        tick();
        clr_in();
        i_freeNext0 = 1'b1;
        chk("c_busy_c3", 32'(o_busy), 32'd1);
        chk("c_complete_c3", 32'(o_complete), 32'd0);
        tick();
        clr_in();
        i_freeNext1 = 1'b1;
        chk("c_complete_c4", 32'(o_complete), 32'd0);
        tick();
        clr_in();
        chk("c_complete_c5", 32'(o_complete), 32'd1);
        tick();

        // Reset while in WAIT with only branch 0 done.
        start_req(32'h5555_AAAA);
        i_ackNext0 = 1'b1; i_ackNext1 = 1'b1; i_freeNext0 = 1'b1;
        tick();
        clr_in();
        chk("d_busy_wait", 32'(o_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("d_complete", 32'(o_complete), 32'd0);
        chk("d_ready", 32'(o_req_ready), 32'd1);
        chk("d_busy", 32'(o_busy), 32'd0);
        chk("d_data", o_data, 32'd0);
        tick();
        chk("d_ready_next", 32'(o_req_ready), 32'd1);

`ifdef MMU_SPLIT_TIMEOUT_EN
        // Final free lands on the expiry cycle: completion wins.
        start_req(32'h0000_0040);
        i_ackNext0 = 1'b1; i_ackNext1 = 1'b1;
        tick();
        clr_in();
        for (int c = 2; c <= 8; c++) begin
            if (c == 8) begin
                i_freeNext0 = 1'b1;
                i_freeNext1 = 1'b1;
            end
            tick();
        end
        clr_in();
        chk("e_complete_c9", 32'(o_complete), 32'd1);
        chk("e_timeout_c9", 32'(o_timeout), 32'd0);
        tick();

        // Branch 1 never freed: timeout eight cycles after entering DISPATCH.
        start_req(32'h0000_0039);
        i_ackNext0 = 1'b1; i_ackNext1 = 1'b1; i_freeNext0 = 1'b1;
        tick();
        clr_in();
        for (int c = 2; c <= 8; c++) begin
            chk("f_timeout_early", 32'(o_timeout), 32'd0);
            tick();
        end
        chk("f_timeout_c9", 32'(o_timeout), 32'd1);
        chk("f_ready_c9", 32'(o_req_ready), 32'd1);
        chk("f_complete_c9", 32'(o_complete), 32'd0);
        // Sticky through a further transaction, cleared only by reset.
        start_req(32'h0000_0077);
        i_ackNext0 = 1'b1; i_ackNext1 = 1'b1; i_freeNext0 = 1'b1; i_freeNext1 = 1'b1;
        tick();
        clr_in();
        tick();
        chk("f_timeout_sticky", 32'(o_timeout), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("f_timeout_rst", 32'(o_timeout), 32'd0);
`else
        // Without the watchdog, WAIT holds indefinitely.
        start_req(32'h0000_0099);
        i_ackNext0 = 1'b1; i_ackNext1 = 1'b1;
        tick();
        clr_in();
        repeat (40) tick();
        chk("g_busy_long", 32'(o_busy), 32'd1);
        chk("g_timeout_long", 32'(o_timeout), 32'd0);
        i_freeNext0 = 1'b1; i_freeNext1 = 1'b1;
        tick();
        clr_in();
        chk("g_complete", 32'(o_complete), 32'd1);
        chk("g_data", o_data, 32'h0000_0099);
`endif
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mmu_split_ctrl.md
MMU_SPLIT_CTRL -- requirements
Module: mmu_split_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: width of the request payload broadcast to both branches.
REQ-002 Parameter TIMEOUT_CYCLES, default 256: watchdog limit in cycles, legal range 2..65535.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_req_valid  in  1  upstream request present.
REQ-006 o_req_ready  out  1  controller accepts a request this cycle.
REQ-007 i_req_data  in  DATA_W  request payload.
REQ-008 o_driveNext0 / o_driveNext1  out  1 each  per-branch dispatch valid.
REQ-009 i_ackNext0 / i_ackNext1  in  1 each  per-branch dispatch accept.
REQ-010 o_data  out  DATA_W  latched payload, shared by both branches.
REQ-011 i_freeNext0 / i_freeNext1  in  1 each  one-cycle branch completion pulse.
REQ-012 o_complete  out  1  one-cycle pulse; both branches have completed.
REQ-013 o_busy  out  1  a transaction is in flight (state not IDLE).
REQ-014 o_timeout  out  1  sticky watchdog error flag.

Function
REQ-015 FSM states: IDLE, DISPATCH, WAIT, COMPLETE; all outputs decode from registers only, with no input-to-output combinational path.
REQ-016 IDLE: o_req_ready=1; on i_req_valid, latch i_req_data into o_data, clear acc[1:0] and done[1:0], go to DISPATCH.
REQ-017 DISPATCH: o_driveNextN = ~acc[N]; o_driveNextN & i_ackNextN sets acc[N]; branches are accepted independently and in any order.
REQ-018 When acc becomes 2'b11 (including acks in the current cycle), go to WAIT.
REQ-019 i_freeNextN sets done[N] only if acc[N] is already set or i_ackNextN is accepted in the same cycle; otherwise it is ignored.
REQ-020 When done becomes 2'b11 (including pulses in the current cycle), go to COMPLETE from DISPATCH or WAIT.
REQ-021 COMPLETE lasts exactly one cycle: o_complete=1, o_req_ready=0, then IDLE.
REQ-022 Minimum latency: request handshake at cycle 0; drives at cycle 1; acks and frees both at cycle 1 give o_complete at cycle 2; next request accepted at cycle 3.
REQ-023 o_data is held stable from capture until the cycle after COMPLETE; i_req_data is ignored outside IDLE.
REQ-024 A repeated i_freeNextN pulse for a branch whose done[N] is already set has no effect.
REQ-025 o_busy = (state != IDLE).

Reset
REQ-026 When rst=1 at a clock edge: state=IDLE, acc=0, done=0, o_data=0, o_timeout=0, watchdog counter=0.
REQ-027 rst asserted mid-transaction aborts the transaction with no o_complete pulse.
REQ-028 While rst=1 and one cycle after release: o_req_ready=1, all other outputs 0.

Configuration
REQ-029 Macro MMU_SPLIT_TIMEOUT_EN compiles the watchdog in or out.
REQ-030 With the macro defined: a 16-bit counter clears on entry to DISPATCH and increments each cycle in DISPATCH or WAIT.
REQ-031 With the macro defined: at count == TIMEOUT_CYCLES-1 without completion, set o_timeout, clear acc and done, go to IDLE, and do not pulse o_complete.
REQ-032 With the macro defined: if completion and expiry occur in the same cycle, completion wins and o_timeout is not set.
REQ-033 With the macro defined: o_timeout is cleared only by rst.
REQ-034 Without the macro: no counter logic; o_timeout is tied 0; the port still exists; DISPATCH and WAIT wait indefinitely.

Verification
REQ-035 Request data 0xA5A5_0001; acks and frees on both branches in cycle 1 -> o_complete=1 in cycle 2; o_req_ready=1 in cycle 3; o_data=0xA5A5_0001 throughout.
REQ-036 Ack branch 0 at cycle 1, branch 1 at cycle 4 -> o_driveNext0 drops at cycle 2; o_driveNext1 stays high through cycle 4; state is WAIT at cycle 5.
REQ-037 i_freeNext1 pulsed before its ack -> pulse ignored; o_complete appears only after a later i_freeNext1 pulse that follows the ack.
REQ-038 rst pulsed for 1 cycle while in WAIT with done=2'b01 -> no o_complete; state is IDLE; o_req_ready=1 the next cycle.
REQ-039 With MMU_SPLIT_TIMEOUT_EN and TIMEOUT_CYCLES=8, branch 1 never freed -> o_timeout=1 eight cycles after entering DISPATCH; state IDLE; no o_complete.
REQ-040 With MMU_SPLIT_TIMEOUT_EN and TIMEOUT_CYCLES=8, final free on the expiry cycle -> o_complete=1 and o_timeout=0.
